// File: rtl/serial_subtractor_framed.sv
// Bit-serial a - b on LSB-first streams, with per-word parallel result, unsigned borrow
// and signed overflow flags. The word framing is resynchronised by the first input.
module serial_subtractor_framed #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             first,
    input  logic             a,
    input  logic             b,
    output logic             diff,
    output logic [WIDTH-1:0] res,
    output logic             res_valid,
    output logic             res_borrow,
    output logic             res_ovf
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [CW-1:0]    cnt;
    logic             borrow;
    logic [WIDTH-1:0] sh;

    logic start;
    logic bin;
    logic bout;
    logic done;

    always_comb begin
        start = in_valid & (first | (cnt == '0));
        bin   = start ? 1'b0 : borrow;
        diff  = in_valid & (a ^ b ^ bin);
        bout  = (~a & b) | (~(a ^ b) & bin);
        done  = in_valid & (cnt == LAST_IDX) & ~first;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            borrow <= 1'b0;
            sh     <= '0;
        end else if (in_valid) begin
            borrow <= bout;
            sh     <= {diff, sh[WIDTH-1:1]};
            // first restarts the frame; this bit is the LSB, so the next index is 1
            if (first) begin
                cnt <= CW'(1);
            end else if (cnt == LAST_IDX) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res        <= '0;
            res_valid  <= 1'b0;
            res_borrow <= 1'b0;
            res_ovf    <= 1'b0;
        end else begin
            res_valid <= done;
            if (done) begin
                res        <= {diff, sh[WIDTH-1:1]};
                res_borrow <= bout;
                // signed overflow: borrow into the sign bit differs from borrow out of it
                res_ovf    <= bin ^ bout;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor_framed.sv
// Directed bench for serial_subtractor_framed (WIDTH = 8) with hand-computed results.
module tb_serial_subtractor_framed;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       first;
    logic       a;
    logic       b;
    logic       diff;
    logic [7:0] res;
    logic       res_valid;
    logic       res_borrow;
    logic       res_ovf;

    int n_cmp;
    int n_err;
    int pulses;

    serial_subtractor_framed #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .first     (first),
        .a         (a),
        .b         (b),
        .diff      (diff),
        .res       (res),
        .res_valid (res_valid),
        .res_borrow(res_borrow),
        .res_ovf   (res_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (res_valid === 1'b1) pulses++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic ab, input logic bb, input logic fb, input logic exp_d);
        @(negedge clk);
        in_valid = 1'b1;
        a        = ab;
        b        = bb;
        first    = fb;
        #1;
        check_eq("diff", {31'd0, diff}, {31'd0, exp_d});
    endtask

    // Bits lo..hi of a word; exp_res supplies the expected serial difference bits.
    task automatic send_bits(input logic [7:0] aw, input logic [7:0] bw, input logic [7:0] exp_res,
                             input int lo, input int hi, input logic fb);
        for (int i = lo; i <= hi; i++) begin
            send_bit(aw[i], bw[i], fb && (i == lo), exp_res[i]);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        a        = 1'b1;
        b        = 1'b0;
        first    = 1'b0;
        #1;
        check_eq("diff_idle", {31'd0, diff}, 32'd0);
    endtask

    task automatic check_res(input string tag, input logic [7:0] exp_res, input logic exp_b,
                             input logic exp_o);
        check_eq({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
        check_eq({tag, "_res"}, {24'd0, res}, {24'd0, exp_res});
        check_eq({tag, "_borrow"}, {31'd0, res_borrow}, {31'd0, exp_b});
        check_eq({tag, "_ovf"}, {31'd0, res_ovf}, {31'd0, exp_o});
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        pulses   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        first    = 1'b0;
        a        = 1'b0;
        b        = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_res", {24'd0, res}, 32'd0);
        check_eq("rst_valid", {31'd0, res_valid}, 32'd0);
        check_eq("rst_borrow", {31'd0, res_borrow}, 32'd0);
        check_eq("rst_ovf", {31'd0, res_ovf}, 32'd0);
        rst_n = 1'b1;

        // 0x05 - 0x03
        send_bits(8'h05, 8'h03, 8'h02, 0, 7, 1'b0);
        idle();
        check_res("w1", 8'h02, 1'b0, 1'b0);
        idle();
        check_eq("w1_pulse_len", {31'd0, res_valid}, 32'd0);

        send_bits(8'h03, 8'h05, 8'hFE, 0, 7, 1'b0);
        idle();
        check_res("w2", 8'hFE, 1'b1, 1'b0);

        send_bits(8'h80, 8'h01, 8'h7F, 0, 7, 1'b0);
        idle();
        check_res("w3", 8'h7F, 1'b0, 1'b1);

        send_bits(8'h7F, 8'hFF, 8'h80, 0, 7, 1'b0);
        idle();
        check_res("w4", 8'h80, 1'b1, 1'b1);
        idle();

        // Stall after bit 4, then back-to-back 0xFF - 0xFF
        pulses = 0;
        send_bits(8'h05, 8'h03, 8'h02, 0, 4, 1'b0);
        idle();
        idle();
        idle();
        check_eq("stall_no_pulse", pulses, 0);
        send_bits(8'h05, 8'h03, 8'h02, 5, 7, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0, 1'b0);
        check_res("w5", 8'h02, 1'b0, 1'b0);
        send_bits(8'hFF, 8'hFF, 8'h00, 1, 7, 1'b0);
        idle();
        check_res("w6", 8'h00, 1'b0, 1'b0);
        idle();
        check_eq("b2b_pulses", pulses, 2);

        // Resync: 3 stray bits, then first starts 0x10 - 0x01
        pulses = 0;
        send_bits(8'hFF, 8'h00, 8'hFF, 0, 2, 1'b0);
        send_bits(8'h10, 8'h01, 8'h0F, 0, 7, 1'b1);
        idle();
        check_res("w7", 8'h0F, 1'b0, 1'b0);
        idle();
        check_eq("resync_pulses", pulses, 1);

        // Reset during bit 5 of a word
        send_bits(8'h33, 8'h11, 8'h22, 0, 4, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_res", {24'd0, res}, 32'd0);
        check_eq("mid_rst_valid", {31'd0, res_valid}, 32'd0);
        check_eq("mid_rst_borrow", {31'd0, res_borrow}, 32'd0);
        check_eq("mid_rst_ovf", {31'd0, res_ovf}, 32'd0);
        check_eq("mid_rst_diff", {31'd0, diff}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_bits(8'hAA, 8'h55, 8'h55, 0, 7, 1'b0);
        idle();
        check_res("w8", 8'h55, 1'b0, 1'b1);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
